// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional address checking is enabled with macro DMEM_ERR_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int          CNT_W        = 4;
  localparam logic [63:0] DEFAULT_BASE = 64'h0000_0000_8000_0000;
  localparam string       ERR_MACRO    = "DMEM_ERR_EN";

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64 synchronous word array with byte enables.
// Access strobe 'we' captures the pre-write word; 'be' selects lanes.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [7:0]    be,
  input  logic [IW-1:0] index,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] r_mem [DEPTH];

  // Loads are strobes with no lanes enabled; read sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      rdata <= r_mem[index];
      for (int i = 0; i < 8; i++) begin
        if (be[i]) begin
          r_mem[index][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_resp_slave.sv
// Data-memory responder: one outstanding load/store, programmable latency.
// Define DMEM_ERR_EN to flag out-of-range addresses instead of wrapping.
module dmem_resp_slave
  import dmem_pkg::*;
#(
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2,
  parameter logic [63:0] BASE    = DEFAULT_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAT_M1 =
    (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);
  localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wen;
  logic [IW-1:0]    r_idx;
  logic [63:0]      r_wdata;
  logic [7:0]       r_wmask;
  logic             r_bad;
  logic             r_err;
  logic             r_ld_ok;

  logic [63:0]   w_off;
  logic [IW-1:0] w_idx;
  logic          w_bad;
  logic          w_idle;
  logic          w_commit;
  logic          w_a_wen;
  logic          w_a_bad;
  logic [IW-1:0] w_a_idx;
  logic [63:0]   w_a_wdata;
  logic [7:0]    w_a_mask;
  logic [7:0]    w_be;
  logic          w_we;
  logic [63:0]   w_rdata;
  logic          w_unused;

  assign w_off    = req_addr - BASE;
  assign w_idx    = w_off[IW+2:3];
  assign w_unused = ^{w_off[63:IW+3], w_off[2:0]};

`ifdef DMEM_ERR_EN
  assign w_bad = (req_addr < BASE) || (w_off >= SPAN);
`else
  assign w_bad = 1'b0;
`endif

  assign w_idle   = (r_state == IDLE);
  assign w_commit = (LATENCY == 0)
                  ? (w_idle && req_valid)
                  : (r_state == WAIT && r_cnt == '0);

  // With zero latency the commit edge is the accept edge.
  assign w_a_wen   = w_idle ? req_wen   : r_wen;
  assign w_a_bad   = w_idle ? w_bad     : r_bad;
  assign w_a_idx   = w_idle ? w_idx     : r_idx;
  assign w_a_wdata = w_idle ? req_wdata : r_wdata;
  assign w_a_mask  = w_idle ? req_wmask : r_wmask;

  assign w_be = (w_a_wen && !w_a_bad) ? w_a_mask : 8'h00;
  assign w_we = w_commit && !rst;

  dmem_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk   (clk),
    .we    (w_we),
    .be    (w_be),
    .index (w_a_idx),
    .wdata (w_a_wdata),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wen   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_bad   <= 1'b0;
      r_err   <= 1'b0;
      r_ld_ok <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_wen   <= req_wen;
            r_idx   <= w_idx;
            r_wdata <= req_wdata;
            r_wmask <= req_wmask;
            r_bad   <= w_bad;
            if (LATENCY == 0) begin
              r_state <= RESP;
              r_err   <= w_bad;
              r_ld_ok <= !req_wen && !w_bad;
            end else begin
              r_state <= WAIT;
              r_cnt   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state <= RESP;
            r_err   <= r_bad;
            r_ld_ok <= !r_wen && !r_bad;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = w_idle;
  assign resp_valid = (r_state == RESP);
  assign resp_err   = (r_state == RESP) && r_err;
  assign resp_rdata = r_ld_ok ? w_rdata : 64'h0;

endmodule

// File: tb/tb_dmem_resp_slave.sv
// Directed bench for dmem_resp_slave: LATENCY=2 and LATENCY=0 instances.
module tb_dmem_resp_slave;

  logic        clk;
  logic        rst2, rst0;
  logic        rv2, rv0;
  logic        wen;
  logic [63:0] addr, wdata;
  logic [7:0]  wmask;
  logic        rready;
  logic        rr2, rsv2, re2;
  logic        rr0, rsv0, re0;
  logic [63:0] rd2, rd0;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  dmem_resp_slave #(.LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst2),
    .req_valid  (rv2),
    .req_ready  (rr2),
    .req_wen    (wen),
    .req_addr   (addr),
    .req_wdata  (wdata),
    .req_wmask  (wmask),
    .resp_valid (rsv2),
    .resp_ready (rready),
    .resp_rdata (rd2),
    .resp_err   (re2)
  );

  dmem_resp_slave #(.LATENCY(0)) dut0 (
    .clk        (clk),
    .rst        (rst0),
    .req_valid  (rv0),
    .req_ready  (rr0),
    .req_wen    (wen),
    .req_addr   (addr),
    .req_wdata  (wdata),
    .req_wmask  (wmask),
    .resp_valid (rsv0),
    .resp_ready (rready),
    .resp_rdata (rd0),
    .resp_err   (re0)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // s=1 selects the zero-latency instance. Called just after an edge.
  task automatic do_req(input bit s, input logic w,
                        input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] m,
                        output logic [63:0] rd, output logic er,
                        output int lat);
    bit ok;
    wen = w; addr = a; wdata = d; wmask = m;
    if (s) rv0 = 1; else rv2 = 1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (s ? rr0 : rr2) ok = 1;
      @(posedge clk); #1;
    end
    rv0 = 0; rv2 = 0;
    if (!ok) chk("accept_timeout", 0, 1);
    lat = 1;
    while (!(s ? rsv0 : rsv2) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = s ? rd0 : rd2;
    er = s ? re0 : re2;
    @(posedge clk); #1;
  endtask

  logic [63:0] rd;
  logic        er;
  int          lat;
  int          t [3];
  logic [63:0] va [3];

  initial begin
    rst2 = 1; rst0 = 1; rv2 = 0; rv0 = 0;
    wen = 0; addr = 0; wdata = 0; wmask = 0; rready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", rr2, 1);
    chk("rst_resp_valid", rsv2, 0);
    chk("rst_rdata", rd2, 0);
    chk("rst_err", re2, 0);
    chk("rst_req_ready0", rr0, 1);
    rst2 = 0; rst0 = 0;
    @(posedge clk); #1;

    do_req(0, 1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, rd, er, lat);
    chk("st_lat", 64'(lat), 3);
    chk("st_rdata", rd, 0);
    chk("st_err", 64'(er), 0);
    do_req(0, 0, 64'h8000_0010, 0, 0, rd, er, lat);
    chk("ld_lat", 64'(lat), 3);
    chk("ld_rdata", rd, 64'h1122334455667788);

    do_req(0, 1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, rd, er, lat);
    do_req(0, 0, 64'h8000_0017, 0, 0, rd, er, lat);
    chk("mask_rdata", rd, 64'h11223344AAAAAAAA);

    // Backpressure: response held while a second request waits.
    rready = 0;
    wen = 0; addr = 64'h8000_0010; rv2 = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 10 && !rsv2; i++) begin
      @(posedge clk); #1;
    end
    chk("bp_valid_rise", rsv2, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", rsv2, 1);
      chk("bp_rdata", rd2, 64'h11223344AAAAAAAA);
      chk("bp_req_ready", rr2, 0);
    end
    rready = 1;
    @(posedge clk); #1;
    chk("bp_idle_ready", rr2, 1);
    chk("bp_idle_valid", rsv2, 0);
    @(posedge clk); #1;
    chk("bp_reaccept", rr2, 0);
    rv2 = 0;
    for (int i = 0; i < 10 && !rsv2; i++) begin
      @(posedge clk); #1;
    end
    chk("bp_second_rdata", rd2, 64'h11223344AAAAAAAA);
    @(posedge clk); #1;

    // Zero latency: stores, then back-to-back loads.
    va[0] = 64'h0101_0202_0303_0404;
    va[1] = 64'hF0E1_D2C3_B4A5_9687;
    va[2] = 64'h0123_4567_89AB_CDEF;
    for (int k = 0; k < 3; k++) begin
      do_req(1, 1, 64'h8000_0100 + 64'(8 * k), va[k], 8'hFF,
             rd, er, lat);
      if (k == 0) chk("l0_st_lat", 64'(lat), 1);
    end
    wen = 0; addr = 64'h8000_0100; rv0 = 1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10 && !rr0; i++) begin
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      chk("l0_valid", rsv0, 1);
      t[k] = cyc;
      chk("l0_rdata", rd0, va[k]);
      if (k < 2) addr = 64'h8000_0108 + 64'(8 * k);
      else rv0 = 0;
      @(posedge clk); #1;
    end
    chk("l0_gap1", 64'(t[1] - t[0]), 2);
    chk("l0_gap2", 64'(t[2] - t[1]), 2);

    // Reset during WAIT drops the store.
    do_req(0, 1, 64'h8000_0020, 64'h5555_6666_7777_8888, 8'hFF,
           rd, er, lat);
    do_req(0, 0, 64'h8000_0010, 0, 0, rd, er, lat);
    chk("idle_rdata_hold", rd2, 64'h11223344AAAAAAAA);
    wen = 1; addr = 64'h8000_0020;
    wdata = 64'hDEAD_BEEF_DEAD_BEEF; wmask = 8'hFF; rv2 = 1;
    @(posedge clk); #1;
    rv2 = 0;
    chk("wait_req_ready", rr2, 0);
    #2 rst2 = 1;
    #1;
    chk("arst_valid", rsv2, 0);
    chk("arst_ready", rr2, 1);
    chk("arst_rdata", rd2, 0);
    chk("arst_err", re2, 0);
    repeat (2) @(posedge clk);
    #1 rst2 = 0;
    @(posedge clk); #1;
    do_req(0, 0, 64'h8000_0020, 0, 0, rd, er, lat);
    chk("arst_no_commit", rd, 64'h5555_6666_7777_8888);

    // Out-of-range addresses.
    do_req(0, 1, 64'h8000_0000, 64'hCAFE_0000_CAFE_0000, 8'hFF,
           rd, er, lat);
    do_req(0, 1, 64'h8000_1FF8, 64'h1FF8_1FF8_1FF8_1FF8, 8'hFF,
           rd, er, lat);
`ifdef DMEM_ERR_EN
    do_req(0, 1, 64'h7FFF_FFF8, 64'h7777, 8'hFF, rd, er, lat);
    chk("err_lo_st", 64'(er), 1);
    chk("err_lo_lat", 64'(lat), 3);
    do_req(0, 0, 64'h7FFF_FFF8, 0, 0, rd, er, lat);
    chk("err_lo_ld", 64'(er), 1);
    chk("err_lo_rdata", rd, 0);
    do_req(0, 1, 64'h8000_2000, 64'h0BAD, 8'hFF, rd, er, lat);
    chk("err_hi_st", 64'(er), 1);
    do_req(0, 0, 64'h8000_1FF8, 0, 0, rd, er, lat);
    chk("err_lo_unchanged", rd, 64'h1FF8_1FF8_1FF8_1FF8);
    do_req(0, 0, 64'h8000_0000, 0, 0, rd, er, lat);
    chk("err_hi_unchanged", rd, 64'hCAFE_0000_CAFE_0000);
`else
    do_req(0, 1, 64'h7FFF_FFF8, 64'h7777, 8'hFF, rd, er, lat);
    chk("wrap_lo_err", 64'(er), 0);
    do_req(0, 0, 64'h8000_1FF8, 0, 0, rd, er, lat);
    chk("wrap_lo_rdata", rd, 64'h7777);
    do_req(0, 1, 64'h8000_2000, 64'h0BAD, 8'hFF, rd, er, lat);
    chk("wrap_hi_err", 64'(er), 0);
    do_req(0, 0, 64'h8000_0000, 0, 0, rd, er, lat);
    chk("wrap_hi_rdata", rd, 64'h0BAD);
`endif

    // A zero-mask store leaves the word intact.
    do_req(0, 1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00,
           rd, er, lat);
    do_req(0, 0, 64'h8000_0010, 0, 0, rd, er, lat);
    chk("nomask_rdata", rd, 64'h11223344AAAAAAAA);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
